// File: rtl/midi_encoder.sv
// MIDI channel-voice message serialiser with optional running-status compression.
// Emits status/data bytes over a valid/ready byte stream toward a UART transmitter.
module midi_encoder #(
   parameter int RUNNING_STATUS    = 1,
   parameter int RS_TIMEOUT_CYCLES = 15000000
) (
   input  logic       clock_50_000_000,
   input  logic       reset_l,
   input  logic [3:0] msg_kind,
   input  logic [3:0] msg_channel,
   input  logic [6:0] msg_data1,
   input  logic [6:0] msg_data2,
   input  logic       msg_valid,
   output logic       msg_ready,
   output logic       msg_error,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready
);

   localparam int CW = $clog2(RS_TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] COUNT_MAX  = CW'(RS_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] COUNT_LAST = CW'(RS_TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    kind_reg, channel_reg;
   logic [6:0]    data1_reg, data2_reg;
   logic [7:0]    status_reg;
   logic          status_valid_reg;
   logic [CW-1:0] count_reg;
   logic          msg_error_reg;

   logic accept, kind_ok, timeout_now, skip_status, byte_hs, one_data_byte;

   assign accept        = msg_valid && (state_reg == IDLE);
   assign kind_ok       = msg_kind[3] && (msg_kind != 4'hF);
   assign byte_hs       = data_out_valid && data_out_ready;
   assign one_data_byte = (kind_reg == 4'hC) || (kind_reg == 4'hD);
   // Timeout landing on the accept edge must already count as expired.
   assign timeout_now   = (state_reg == IDLE) && status_valid_reg && (count_reg >= COUNT_LAST);
   assign skip_status   = (RUNNING_STATUS != 0) && status_valid_reg && !timeout_now
                          && ({msg_kind, msg_channel} == status_reg);
   assign msg_error     = msg_error_reg;

   always_comb begin
      state_next     = state_reg;
      msg_ready      = 1'b0;
      data_out_valid = 1'b1;
      data_out       = 8'h00;
      case (state_reg)
         IDLE: begin
            msg_ready      = 1'b1;
            data_out_valid = 1'b0;
            if (accept && kind_ok)
               state_next = skip_status ? DATA1 : STATUS;
         end
         STATUS: begin
            data_out = {kind_reg, channel_reg};
            if (data_out_ready)
               state_next = DATA1;
         end
         DATA1: begin
            data_out = {1'b0, data1_reg};
            if (data_out_ready)
               state_next = one_data_byte ? IDLE : DATA2;
         end
         DATA2: begin
            data_out = {1'b0, data2_reg};
            if (data_out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         state_reg        <= IDLE;
         kind_reg         <= 4'h0;
         channel_reg      <= 4'h0;
         data1_reg        <= 7'h00;
         data2_reg        <= 7'h00;
         status_reg       <= 8'h00;
         status_valid_reg <= 1'b0;
         count_reg        <= '0;
         msg_error_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         msg_error_reg <= accept && !kind_ok;
         if (accept) begin
            kind_reg    <= msg_kind;
            channel_reg <= msg_channel;
            data1_reg   <= msg_data1;
            data2_reg   <= msg_data2;
         end
         if ((state_reg == STATUS) && data_out_ready) begin
            status_reg       <= {kind_reg, channel_reg};
            status_valid_reg <= 1'b1;
         end else if (timeout_now) begin
            status_valid_reg <= 1'b0;
         end
         // Idle-time counter; stalls never advance it because it only runs in IDLE.
         if (byte_hs)
            count_reg <= '0;
         else if ((state_reg == IDLE) && status_valid_reg && (count_reg < COUNT_MAX))
            count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: tb/tb_midi_encoder.sv
// Randomised self-checking bench for midi_encoder: one running-status instance and
// one always-status instance, each checked against a message-level byte model.
module tb_midi_encoder;

   localparam int T = 8;

   logic       clock_50_000_000 = 1'b0;
   logic       reset_l;
   logic [3:0] kind_s [2];
   logic [3:0] chan_s [2];
   logic [6:0] d1_s   [2];
   logic [6:0] d2_s   [2];
   logic       mv_s   [2];
   logic       mr_s   [2];
   logic       me_s   [2];
   logic [7:0] do_s   [2];
   logic       dov_s  [2];
   logic       dor_s  [2];

   always #5 clock_50_000_000 = ~clock_50_000_000;

   midi_encoder #(.RUNNING_STATUS(1), .RS_TIMEOUT_CYCLES(T)) dut_rs (
      .clock_50_000_000(clock_50_000_000), .reset_l(reset_l),
      .msg_kind(kind_s[0]), .msg_channel(chan_s[0]), .msg_data1(d1_s[0]), .msg_data2(d2_s[0]),
      .msg_valid(mv_s[0]), .msg_ready(mr_s[0]), .msg_error(me_s[0]),
      .data_out(do_s[0]), .data_out_valid(dov_s[0]), .data_out_ready(dor_s[0]));

   midi_encoder #(.RUNNING_STATUS(0), .RS_TIMEOUT_CYCLES(T)) dut_nrs (
      .clock_50_000_000(clock_50_000_000), .reset_l(reset_l),
      .msg_kind(kind_s[1]), .msg_channel(chan_s[1]), .msg_data1(d1_s[1]), .msg_data2(d2_s[1]),
      .msg_valid(mv_s[1]), .msg_ready(mr_s[1]), .msg_error(me_s[1]),
      .data_out(do_s[1]), .data_out_valid(dov_s[1]), .data_out_ready(dor_s[1]));

   int cyc = 0;
   always @(posedge clock_50_000_000) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   // Model: last status sent on the wire and edge index of the last byte handshake.
   bit         st_valid [2];
   logic [7:0] st_byte  [2];
   int         last_hs  [2];

   task automatic tick;
      @(posedge clock_50_000_000);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick;
   endtask

   task automatic model_reset;
      for (int u = 0; u < 2; u++) begin
         st_valid[u] = 1'b0;
         st_byte[u]  = 8'h00;
         last_hs[u]  = 0;
      end
   endtask

   // mode: 0 ready always high, 1 ready alternates, 2 ready random
   task automatic send(input int u, input logic [3:0] k, input logic [3:0] ch,
                       input logic [6:0] a, input logic [6:0] b, input int mode);
      logic [7:0] exp_q[$];
      logic [7:0] s;
      int         waited;
      int         acc;
      int         spin;
      bit         rdy;
      kind_s[u] = k; chan_s[u] = ch; d1_s[u] = a; d2_s[u] = b; mv_s[u] = 1'b1;
      waited = 0;
      while (mr_s[u] !== 1'b1 && waited < 50) begin
         tick;
         waited++;
      end
      total++;
      if (mr_s[u] !== 1'b1) $display("FAIL accept_wait u=%0d msg_ready=%b required 1", u, mr_s[u]);
      else passed++;
      tick;
      acc = cyc;
      mv_s[u] = 1'b0;
      if (!(k >= 4'h8 && k != 4'hF)) begin
         total++;
         if (me_s[u] !== 1'b1 || dov_s[u] !== 1'b0)
            $display("FAIL error_pulse u=%0d msg_error=%b data_out_valid=%b required 1/0", u, me_s[u], dov_s[u]);
         else passed++;
         tick;
         total++;
         if (me_s[u] !== 1'b0 || mr_s[u] !== 1'b1 || dov_s[u] !== 1'b0)
            $display("FAIL error_end u=%0d msg_error=%b msg_ready=%b dov=%b required 0/1/0", u, me_s[u], mr_s[u], dov_s[u]);
         else passed++;
         $display("msg u=%0d kind=%h ch=%0d dropped (invalid kind)", u, k, ch);
         return;
      end
      s = {k, ch};
      if (u == 1 || !st_valid[u] || st_byte[u] != s || (acc - last_hs[u]) >= T)
         exp_q.push_back(s);
      st_valid[u] = 1'b1;
      st_byte[u]  = s;
      exp_q.push_back({1'b0, a});
      if (k != 4'hC && k != 4'hD) exp_q.push_back({1'b0, b});
      for (int i = 0; i < exp_q.size(); i++) begin
         spin = 0;
         do begin
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (cyc % 2) == 0;
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (spin >= 40) rdy = 1'b1;
            dor_s[u] = rdy;
            total++;
            if (dov_s[u] !== 1'b1 || do_s[u] !== exp_q[i])
               $display("FAIL byte u=%0d idx=%0d got valid=%b data=%h required valid=1 data=%h",
                        u, i, dov_s[u], do_s[u], exp_q[i]);
            else passed++;
            tick;
            spin++;
         end while (!rdy);
      end
      last_hs[u] = cyc;
      dor_s[u]   = 1'b0;
      total++;
      if (mr_s[u] !== 1'b1 || dov_s[u] !== 1'b0 || me_s[u] !== 1'b0)
         $display("FAIL msg_done u=%0d msg_ready=%b dov=%b msg_error=%b required 1/0/0", u, mr_s[u], dov_s[u], me_s[u]);
      else passed++;
      $display("msg u=%0d kind=%h ch=%0d d1=%h d2=%h gap=%0d bytes=%0d", u, k, ch, a, b, acc - last_hs[u] + 0, exp_q.size());
   endtask

   task automatic check_idle_outputs(input string name);
      for (int u = 0; u < 2; u++) begin
         total++;
         if (mr_s[u] !== 1'b1 || dov_s[u] !== 1'b0 || do_s[u] !== 8'h00 || me_s[u] !== 1'b0)
            $display("FAIL %s u=%0d ready=%b dov=%b data=%h err=%b required 1/0/00/0",
                     name, u, mr_s[u], dov_s[u], do_s[u], me_s[u]);
         else passed++;
      end
   endtask

   task automatic test_reset;
      reset_l = 1'b0;
      for (int u = 0; u < 2; u++) begin
         kind_s[u] = 4'h0; chan_s[u] = 4'h0; d1_s[u] = 7'h0; d2_s[u] = 7'h0;
         mv_s[u] = 1'b0; dor_s[u] = 1'b0;
      end
      model_reset;
      idle(3);
      check_idle_outputs("reset_state");
      reset_l = 1'b1;
      idle(2);
      check_idle_outputs("after_reset");
   endtask

   task automatic test_running_status;
      send(0, 4'hB, 4'h0, 7'h14, 7'd10, 0);
      send(0, 4'hB, 4'h0, 7'h15, 7'd20, 0);
      send(0, 4'h9, 4'h0, 7'd30, 7'd0, 0);
   endtask

   task automatic test_no_running_status;
      send(1, 4'h9, 4'h3, 7'd60, 7'd100, 0);
      send(1, 4'h9, 4'h3, 7'd60, 7'd100, 0);
   endtask

   task automatic test_short_messages;
      send(0, 4'hC, 4'h5, 7'd7, 7'h55, 0);
      send(0, 4'hD, 4'h5, 7'd9, 7'h33, 0);
      send(0, 4'hD, 4'h5, 7'd11, 7'h22, 0);
   endtask

   task automatic test_backpressure;
      send(0, 4'hE, 4'h1, 7'h00, 7'h40, 1);
      send(1, 4'hE, 4'h1, 7'h00, 7'h40, 1);
   endtask

   task automatic test_timeout;
      send(0, 4'hB, 4'h0, 7'd1, 7'd2, 0);
      idle(T - 1);
      send(0, 4'hB, 4'h0, 7'd1, 7'd2, 0);
      idle(T - 2);
      send(0, 4'hB, 4'h0, 7'd1, 7'd2, 0);
   endtask

   task automatic test_error;
      send(0, 4'h4, 4'h0, 7'd1, 7'd2, 0);
      send(0, 4'hF, 4'h2, 7'd1, 7'd2, 0);
      send(0, 4'hB, 4'h0, 7'd3, 7'd4, 0);
   endtask

   task automatic test_reset_mid_data1;
      send(0, 4'h9, 4'h0, 7'd10, 7'd80, 0);
      kind_s[0] = 4'h9; chan_s[0] = 4'h0; d1_s[0] = 7'd10; d2_s[0] = 7'd80;
      mv_s[0] = 1'b1; dor_s[0] = 1'b0;
      tick;
      mv_s[0] = 1'b0;
      idle(2);
      total++;
      if (dov_s[0] !== 1'b1 || do_s[0] !== 8'h0A)
         $display("FAIL stalled_data1 got valid=%b data=%h required 1/0a", dov_s[0], do_s[0]);
      else passed++;
      #2 reset_l = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      model_reset;
      dor_s[0] = 1'b1;
      idle(2);
      reset_l = 1'b1;
      dor_s[0] = 1'b0;
      idle(1);
      check_idle_outputs("after_mid_reset");
      send(0, 4'h9, 4'h0, 7'd10, 7'd80, 0);
   endtask

   task automatic test_random;
      logic [3:0] ktab [10];
      ktab = '{4'hB, 4'hB, 4'h9, 4'hC, 4'hD, 4'hE, 4'h8, 4'hA, 4'h4, 4'hF};
      for (int n = 0; n < 40; n++) begin
         int u;
         u = int'($urandom_range(0, 1));
         idle(int'($urandom_range(0, 10)));
         send(u, ktab[$urandom_range(0, 9)], 4'($urandom_range(0, 1)),
              7'($urandom), 7'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset;
      test_running_status;
      test_no_running_status;
      test_short_messages;
      test_backpressure;
      test_timeout;
      test_error;
      test_reset_mid_data1;
      test_random;
      idle(2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
